timer_apb_regs: RTL and testbench

APB responder and register bank for the 8-bit timer. It decodes APB accesses from the bus into four byte-wide registers: TDR, TCR, TSR and TCNT. It drives the counter's load/data/enable/clock-select controls and reads back the live count. It captures the counter's overflow and underflow pulses as sticky, write-1-to-clear status flags.

---
 rtl/timer_pkg.sv | 44 ++++
 rtl/timer_sticky_flag.sv | 47 ++++
 rtl/timer_apb_regs.sv | 237 +++++++++++++++++++++++
 tb/tb_timer_apb_regs.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the 8-bit timer's APB register bank:
//   - byte addresses of the four registers (TDR, TCR, TSR, TCNT)
//   - TCR / TSR bit positions and the TCR write mask
//   - the APB responder state enum
//   - addrError(): decides whether an access gets an error response
// ---------------------------------------------------------------------------
package timer_pkg;

  // Register byte addresses
  localparam logic [7:0] ADDR_TDR  = 8'h00;
  localparam logic [7:0] ADDR_TCR  = 8'h01;
  localparam logic [7:0] ADDR_TSR  = 8'h02;
  localparam logic [7:0] ADDR_TCNT = 8'h03;

  // TCR bit positions; bits 6, 3 and 2 always read 0 and ignore writes
  localparam int TCR_LOAD_BIT = 7;
  localparam int TCR_DOWN_BIT = 5;
  localparam int TCR_EN_BIT   = 4;
  localparam int TCR_CKS_MSB  = 1;
  localparam int TCR_CKS_LSB  = 0;

  // Only implemented TCR bits can be written; the rest always read 0
  localparam logic [7:0] TCR_WMASK = 8'hB3;

  // TSR bit positions
  localparam int TSR_OVF_BIT = 0;
  localparam int TSR_UDF_BIT = 1;

  // APB responder states
  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT,
    ACCESS
  } apb_state_e;

  // Unmapped addresses always error; TCNT is read-only, so writing it errors too
  function automatic logic addrError(input logic [7:0] addr, input logic isWrite);
    return (addr > ADDR_TCNT) || (isWrite && (addr == ADDR_TCNT));
  endfunction

endpackage

// File: rtl/timer_sticky_flag.sv
// ---------------------------------------------------------------------------
// timer_sticky_flag
// One sticky status bit. A set pulse latches the flag high; a clear pulse
// (write-1-to-clear from the bus) drops it. When both arrive in the same
// cycle the set wins, so an event coinciding with a clear is never lost.
// Ports:
//   clk_i   system clock
//   rst_i   asynchronous reset, active-high (flag goes to 0)
//   set_i   one-cycle event pulse
//   clr_i   one-cycle clear request
//   flag_o  current flag value
// ---------------------------------------------------------------------------
module timer_sticky_flag
  import timer_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic set_i,
  input  logic clr_i,
  output logic flag_o
);

  logic flag_q;
  logic flag_d;

  // Next value: set has priority over clear, otherwise hold
  always_comb begin
    flag_d = flag_q;
    if (set_i) begin
      flag_d = 1'b1;
    end else if (clr_i) begin
      flag_d = 1'b0;
    end
  end

  // Flag storage, cleared asynchronously by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/timer_apb_regs.sv
// ---------------------------------------------------------------------------
// timer_apb_regs
// APB responder and register bank for the 8-bit timer.
//   0x00 TDR  R/W  load value, drives o_datain
//   0x01 TCR  R/W  [7] load (o_wren), [5] down, [4] en, [1:0] cks
//   0x02 TSR  W1C  [0] overflow, [1] underflow (sticky)
//   0x03 TCNT RO   live counter value i_count
// Other addresses, and writes to TCNT, complete with o_pslverr=1 and no effect.
//
// Parameter:
//   WAIT_CYCLES  wait states inserted before o_pready (0..15)
// Ports:
//   i_clk_sys, i_rst               clock, async active-high reset
//   i_psel, i_penable, i_pwrite,
//   i_paddr, i_pwdata              APB request
//   o_prdata, o_pready, o_pslverr  APB response
//   i_count, i_ovf, i_udf          counter status in
//   o_wren, o_datain, o_en,
//   o_down, o_cks                  counter controls out
//
// The state register is updated at the edge ending each bus cycle, so the
// setup cycle itself is recognised from IDLE (or ACCESS for back-to-back)
// and captured at its closing edge. SETUP is then held during the first
// enable cycle, WAIT covers any further wait states, and ACCESS is the
// cycle in which the registered o_pready is high. Net effect: o_pready
// rises WAIT_CYCLES cycles after the first enable cycle.
// ---------------------------------------------------------------------------
module timer_apb_regs
  import timer_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic       i_clk_sys,
  input  logic       i_rst,
  input  logic       i_psel,
  input  logic       i_penable,
  input  logic       i_pwrite,
  input  logic [7:0] i_paddr,
  input  logic [7:0] i_pwdata,
  output logic [7:0] o_prdata,
  output logic       o_pready,
  output logic       o_pslverr,
  input  logic [7:0] i_count,
  input  logic       i_ovf,
  input  logic       i_udf,
  output logic       o_wren,
  output logic [7:0] o_datain,
  output logic       o_en,
  output logic       o_down,
  output logic [1:0] o_cks
);

  localparam logic [4:0] WaitLimit = 5'(WAIT_CYCLES);

  apb_state_e state_q, state_d;
  logic [3:0] waitCnt_q, waitCnt_d;
  logic [4:0] waitInc;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       write_q, write_d;
  logic       pready_q, pready_d;
  logic       pslverr_q, pslverr_d;
  logic [7:0] tdr_q, tdr_d;
  logic [7:0] tcr_q, tcr_d;
  logic       captureSetup;
  logic       commit;
  logic       clrOvf;
  logic       clrUdf;
  logic       ovfFlag;
  logic       udfFlag;
  logic [7:0] tsrValue;
  logic [7:0] readMux;

  assign waitInc = {1'b0, waitCnt_q} + 5'd1;

  // Responder FSM next state. A setup cycle (psel high, penable low) seen in
  // IDLE or ACCESS starts a transfer and captures address/direction/data.
  // Dropping psel before ACCESS abandons the transfer without a response.
  always_comb begin
    state_d      = state_q;
    waitCnt_d    = waitCnt_q;
    captureSetup = 1'b0;
    case (state_q)
      IDLE: begin
        waitCnt_d = 4'd0;
        if (i_psel && !i_penable) begin
          captureSetup = 1'b1;
          state_d      = (WAIT_CYCLES == 0) ? ACCESS : SETUP;
        end
      end
      SETUP: begin
        if (!i_psel) begin
          state_d = IDLE;
        end else if (i_penable) begin
          if (WAIT_CYCLES <= 1) begin
            state_d = ACCESS;
          end else begin
            state_d   = WAIT;
            waitCnt_d = 4'd1;
          end
        end
      end
      WAIT: begin
        if (!i_psel) begin
          state_d = IDLE;
        end else if (waitInc >= WaitLimit) begin
          state_d = ACCESS;
        end else begin
          waitCnt_d = waitInc[3:0];
        end
      end
      ACCESS: begin
        waitCnt_d = 4'd0;
        if (i_psel && !i_penable) begin
          captureSetup = 1'b1;
          state_d      = (WAIT_CYCLES == 0) ? ACCESS : SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request capture: the setup-cycle values are what gets decoded, so later
  // changes on the bus during the enable cycles cannot affect the transfer
  always_comb begin
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    if (captureSetup) begin
      addr_d  = i_paddr;
      write_d = i_pwrite;
      wdata_d = i_pwdata;
    end
  end

  // Response flags are registered: they are high exactly in ACCESS, and the
  // error decision uses the request that ACCESS will complete
  always_comb begin
    pready_d  = (state_d == ACCESS);
    pslverr_d = pready_d && addrError(addr_d, write_d);
  end

  // A write commits on the edge that ends ACCESS, and only to a valid target
  always_comb begin
    commit = (state_q == ACCESS) && write_q;
    tdr_d  = tdr_q;
    tcr_d  = tcr_q;
    clrOvf = 1'b0;
    clrUdf = 1'b0;
    if (commit) begin
      case (addr_q)
        ADDR_TDR: tdr_d = wdata_q;
        ADDR_TCR: tcr_d = wdata_q & TCR_WMASK;
        ADDR_TSR: begin
          clrOvf = wdata_q[TSR_OVF_BIT];
          clrUdf = wdata_q[TSR_UDF_BIT];
        end
        default: ;
      endcase
    end
  end

  // Read data is driven only during a read ACCESS. TSR shows the flags as
  // they stand before the closing edge; TCNT shows the live count.
  always_comb begin
    readMux = 8'h00;
    if ((state_q == ACCESS) && !write_q) begin
      case (addr_q)
        ADDR_TDR:  readMux = tdr_q;
        ADDR_TCR:  readMux = tcr_q;
        ADDR_TSR:  readMux = tsrValue;
        ADDR_TCNT: readMux = i_count;
        default:   readMux = 8'h00;
      endcase
    end
  end

  // All bus and register state, cleared asynchronously so a reset in the
  // middle of a transfer drops o_pready at once and nothing gets committed
  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      waitCnt_q <= 4'd0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      write_q   <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      tdr_q     <= 8'h00;
      tcr_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      tdr_q     <= tdr_d;
      tcr_q     <= tcr_d;
    end
  end

  // Sticky status flags; events are captured every cycle regardless of the bus
  timer_sticky_flag u_ovf_flag (
    .clk_i  (i_clk_sys),
    .rst_i  (i_rst),
    .set_i  (i_ovf),
    .clr_i  (clrOvf),
    .flag_o (ovfFlag)
  );

  timer_sticky_flag u_udf_flag (
    .clk_i  (i_clk_sys),
    .rst_i  (i_rst),
    .set_i  (i_udf),
    .clr_i  (clrUdf),
    .flag_o (udfFlag)
  );

  assign tsrValue  = {6'b000000, udfFlag, ovfFlag};

  assign o_prdata  = readMux;
  assign o_pready  = pready_q;
  assign o_pslverr = pslverr_q;

  assign o_wren    = tcr_q[TCR_LOAD_BIT];
  assign o_datain  = tdr_q;
  assign o_en      = tcr_q[TCR_EN_BIT];
  assign o_down    = tcr_q[TCR_DOWN_BIT];
  assign o_cks     = tcr_q[TCR_CKS_MSB:TCR_CKS_LSB];

endmodule

// File: tb/tb_timer_apb_regs.sv
// ---------------------------------------------------------------------------
// tb_timer_apb_regs
// Self-checking bench for timer_apb_regs (WAIT_CYCLES = 1). APB transfers
// push their expected read data / error flag into a scoreboard queue; the
// entry is popped and compared when the DUT raises o_pready.
// ---------------------------------------------------------------------------
module tb_timer_apb_regs;

  localparam int unsigned WAIT = 1;

  logic       clock;
  logic       reset;
  logic       i_psel;
  logic       i_penable;
  logic       i_pwrite;
  logic [7:0] i_paddr;
  logic [7:0] i_pwdata;
  logic [7:0] o_prdata;
  logic       o_pready;
  logic       o_pslverr;
  logic [7:0] i_count;
  logic       i_ovf;
  logic       i_udf;
  logic       o_wren;
  logic [7:0] o_datain;
  logic       o_en;
  logic       o_down;
  logic [1:0] o_cks;

  typedef struct {
    string      tag;
    logic [7:0] data;
    logic       err;
  } sbEntry_t;

  sbEntry_t sbQueue[$];
  int checkCount = 0;
  int passCount  = 0;

  timer_apb_regs #(.WAIT_CYCLES(WAIT)) dut (
    .i_clk_sys (clock),
    .i_rst     (reset),
    .i_psel    (i_psel),
    .i_penable (i_penable),
    .i_pwrite  (i_pwrite),
    .i_paddr   (i_paddr),
    .i_pwdata  (i_pwdata),
    .o_prdata  (o_prdata),
    .o_pready  (o_pready),
    .o_pslverr (o_pslverr),
    .i_count   (i_count),
    .i_ovf     (i_ovf),
    .i_udf     (i_udf),
    .o_wren    (o_wren),
    .o_datain  (o_datain),
    .o_en      (o_en),
    .o_down    (o_down),
    .o_cks     (o_cks)
  );

  // Free-running 100 MHz clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Safety net in case something stalls outside the bounded waits
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check, reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end else begin
      passCount++;
    end
  endtask

  // One complete APB transfer. pulseMask {udf,ovf} raises the status inputs
  // during the ACCESS cycle so they land on the commit edge.
  task automatic applyStimulus(input logic wr, input logic [7:0] addr,
                               input logic [7:0] wdata, input logic [1:0] pulseMask,
                               input logic [7:0] expData, input logic expErr);
    sbEntry_t e;
    sbEntry_t got;
    int cycles;
    bit seen;
    e.tag  = wr ? $sformatf("wr%02h", addr) : $sformatf("rd%02h", addr);
    e.data = expData;
    e.err  = expErr;
    sbQueue.push_back(e);
    @(posedge clock); #1;
    i_psel = 1'b1; i_penable = 1'b0; i_pwrite = wr; i_paddr = addr; i_pwdata = wdata;
    @(posedge clock); #1;
    i_penable = 1'b1;
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 20) begin
      @(negedge clock);
      cycles++;
      if (o_pready) seen = 1'b1;
    end
    if (seen) begin
      got = sbQueue.pop_front();
      checkOutput({got.tag, "_data"}, 32'(o_prdata), 32'(got.data));
      checkOutput({got.tag, "_err"}, 32'(o_pslverr), 32'(got.err));
      checkOutput({got.tag, "_latency"}, 32'(cycles), 32'(WAIT + 1));
      i_ovf = pulseMask[0];
      i_udf = pulseMask[1];
    end else begin
      checkOutput({e.tag, "_timeout"}, 32'(0), 32'(1));
      void'(sbQueue.pop_front());
    end
    @(posedge clock); #1;
    i_psel = 1'b0; i_penable = 1'b0; i_ovf = 1'b0; i_udf = 1'b0;
    @(negedge clock);
    checkOutput({e.tag, "_preadyOneCycle"}, 32'(o_pready), 32'(0));
  endtask

  initial begin
    reset = 1'b1; i_psel = 1'b0; i_penable = 1'b0; i_pwrite = 1'b0;
    i_paddr = 8'h00; i_pwdata = 8'h00; i_count = 8'h5A; i_ovf = 1'b0; i_udf = 1'b0;
    repeat (3) @(negedge clock);

    // Reset values
    checkOutput("rstPready",  32'(o_pready),  32'(0));
    checkOutput("rstPslverr", 32'(o_pslverr), 32'(0));
    checkOutput("rstPrdata",  32'(o_prdata),  32'(0));
    checkOutput("rstCtrl", 32'({o_wren, o_en, o_down, o_cks, o_datain}), 32'(0));
    @(posedge clock); #1;
    reset = 1'b0;

    // Reads after reset
    applyStimulus(1'b0, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h01, 8'h00, 2'b00, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h02, 8'h00, 2'b00, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h03, 8'h00, 2'b00, 8'h5A, 1'b0);

    // Control registers and counter controls
    applyStimulus(1'b1, 8'h00, 8'hC8, 2'b00, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h01, 8'hFF, 2'b00, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h01, 8'h00, 2'b00, 8'hB3, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 2'b00, 8'hC8, 1'b0);
    checkOutput("datain", 32'(o_datain), 32'h00C8);
    checkOutput("wren",   32'(o_wren),   32'(1));
    checkOutput("en",     32'(o_en),     32'(1));
    checkOutput("down",   32'(o_down),   32'(1));
    checkOutput("cks",    32'(o_cks),    32'(3));

    // Overflow flag: set by a pulse, cleared by W1C
    @(posedge clock); #1; i_ovf = 1'b1;
    @(posedge clock); #1; i_ovf = 1'b0;
    applyStimulus(1'b0, 8'h02, 8'h00, 2'b00, 8'h01, 1'b0);
    applyStimulus(1'b1, 8'h02, 8'h01, 2'b00, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h02, 8'h00, 2'b00, 8'h00, 1'b0);

    // Underflow set coinciding with its W1C clear: set wins
    @(posedge clock); #1; i_udf = 1'b1;
    @(posedge clock); #1; i_udf = 1'b0;
    applyStimulus(1'b0, 8'h02, 8'h00, 2'b00, 8'h02, 1'b0);
    applyStimulus(1'b1, 8'h02, 8'h02, 2'b10, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h02, 8'h00, 2'b00, 8'h02, 1'b0);
    applyStimulus(1'b1, 8'h02, 8'h02, 2'b00, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h02, 8'h00, 2'b00, 8'h00, 1'b0);

    // Pulse during a TSR read shows up on the following read
    applyStimulus(1'b0, 8'h02, 8'h00, 2'b01, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h02, 8'h00, 2'b00, 8'h01, 1'b0);
    applyStimulus(1'b1, 8'h02, 8'h01, 2'b00, 8'h00, 1'b0);

    // Error responses leave registers untouched
    i_count = 8'hA5;
    applyStimulus(1'b1, 8'h03, 8'h77, 2'b00, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h10, 8'h00, 2'b00, 8'h00, 1'b1);
    applyStimulus(1'b1, 8'h10, 8'h99, 2'b00, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h03, 8'h00, 2'b00, 8'hA5, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 2'b00, 8'hC8, 1'b0);
    applyStimulus(1'b0, 8'h01, 8'h00, 2'b00, 8'hB3, 1'b0);

    // penable without a setup phase is ignored
    @(posedge clock); #1; i_psel = 1'b0; i_penable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("idlePenable", 32'(o_pready), 32'(0));
    end
    @(posedge clock); #1; i_penable = 1'b0;

    // Transfer abandoned after setup: no response, no write
    @(posedge clock); #1;
    i_psel = 1'b1; i_penable = 1'b0; i_pwrite = 1'b1; i_paddr = 8'h00; i_pwdata = 8'h55;
    @(posedge clock); #1; i_psel = 1'b0; i_penable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("abortPready", 32'(o_pready), 32'(0));
    end
    @(posedge clock); #1; i_penable = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 2'b00, 8'hC8, 1'b0);

    // Reset during the wait cycle of a TDR write
    @(posedge clock); #1;
    i_psel = 1'b1; i_penable = 1'b0; i_pwrite = 1'b1; i_paddr = 8'h00; i_pwdata = 8'h33;
    @(posedge clock); #1; i_penable = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("rstMidPready", 32'(o_pready), 32'(0));
    checkOutput("rstMidFsm", 32'(dut.state_q), 32'(timer_pkg::IDLE));
    checkOutput("rstMidCtrl", 32'({o_wren, o_en, o_down, o_cks, o_datain}), 32'(0));
    @(posedge clock); #1;
    i_psel = 1'b0; i_penable = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h01, 8'h00, 2'b00, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
